fcmp_axis_issuer: RTL
=====================

// Module: fcmp_axis_issuer
// PURPOSE
//  Master/consumer end of the AXI-stream float-compare core (a<b, 32-bit IEEE-754).
//  Takes operand pairs from the JRT datapath over a valid/ready port and drives s_axis_a/s_axis_b
//  with real tvalid/tready handshaking. It accepts m_axis_result with real tready and buffers
//  results in a FIFO. A credit count bounds in-flight requests, so the core is never stalled by
//  a full result buffer.
// PARAMETERS
//  DEPTH   4   result FIFO entries and max outstanding requests; power of 2, >=2
//  CW      3   credit/occupancy counter width; must equal clog2(DEPTH)+1
// PORTS
//  clk                   in   1   single clock, rising edge
//  rst_n                 in   1   asynchronous reset, active low
//  in_valid              in   1   operand pair valid
//  in_ready              out  1   operand pair accepted when in_valid&&in_ready
//  in_a                  in   32  operand a (float)
//  in_b                  in   32  operand b (float)
//  s_axis_a_tvalid       out  1   operand a valid to core
//  s_axis_a_tready       in   1   core accepts a
//  s_axis_a_tdata        out  32  operand a to core
//  s_axis_b_tvalid       out  1   operand b valid to core
//  s_axis_b_tready       in   1   core accepts b
//  s_axis_b_tdata        out  32  operand b to core
//  m_axis_result_tvalid  in   1   core result valid
//  m_axis_result_tready  out  1   result accepted
//  m_axis_result_tdata   in   8   core result; bit0 = (a<b)
//  out_valid             out  1   buffered result available
//  out_ready             in   1   consumer pops result
//  out_lt                out  1   head result, bit0 of stored tdata
//  credits               out  CW  requests accepted and not yet popped (0..DEPTH)
//  err                   out  1   sticky: result arrived with FIFO full or no request outstanding
// BEHAVIOUR
//  Reset (rst_n=0, async): a_pend=b_pend=0, FIFO empty, credits=0, err=0. After reset:
//    tvalids=0, out_valid=0, m_axis_result_tready=1, in_ready=1. Operand regs reset to 0.
//  Issue: in_ready = !a_pend && !b_pend && (credits<DEPTH), combinational. On accept:
//    register in_a/in_b into tdata regs, set a_pend=b_pend=1.
//  s_axis_a_tvalid=a_pend, s_axis_b_tvalid=b_pend. Channels handshake independently:
//    a_pend clears on a_tvalid&&a_tready; b_pend clears on b_tvalid&&b_tready.
//    tdata is held stable while its tvalid=1.
//  Next accept is possible in the cycle after both channels complete, so peak rate is 1 pair/2 cycles.
//  Result: m_axis_result_tready = !fifo_full. On tvalid&&tready, push tdata[0].
//  Result with tvalid=1 while outstanding==0 (credits==fifo occupancy): set err=1 and drop the
//    result (no push).
//  tvalid=1 while FIFO full: tready=0 and nothing is pushed. Credits make this unreachable for a
//    compliant core.
//  Output: out_valid = !fifo_empty; out_lt = FIFO head; pop on out_valid&&out_ready.
//    FIFO latency: push at edge N gives out_valid=1 after edge N.
//  Push and pop in the same cycle: both occur and occupancy is unchanged. Push while full is not
//    possible because tready=0.
//  Credits: +1 on accept, -1 on pop, unchanged on simultaneous accept+pop. Saturates at DEPTH via
//    in_ready. Never underflows, because pop requires out_valid.
//  FIFO pointers are clog2(DEPTH) bits and wrap modulo DEPTH; occupancy is CW bits.
//  err is cleared only by reset.
//  Reset mid-operation: pending operands, buffered results and credits are discarded. Late core
//    results after reset are treated as spurious and set err.
// TESTING
//  1 Reset then single pair a=0x3F800000(1.0), b=0x40000000(2.0), both treadys=1, core returns
//    0x01 -> out_valid=1, out_lt=1, credits=1; pop -> credits=0.
//  2 a_tready=1, b_tready held 0 for 3 cycles -> a_tvalid drops after 1 cycle; b_tvalid and
//    b_tdata stay stable 3 cycles; in_ready=0 until b accepted.
//  3 out_ready=0, issue DEPTH=4 pairs -> in_ready=0 after 4th accept, credits=4; 5th in_valid
//    stalls; one pop -> in_ready=1 next cycle.
//  4 FIFO full with out_ready=1 and new result the same cycle it frees -> tready follows !full.
//    Order preserved across pointer wrap over 10 pairs (alternating 1/0 results).
//  5 m_axis_result_tvalid=1 with credits=0 -> err=1, nothing pushed, out_valid=0; err stays 1
//    until rst_n=0.
//  6 Assert rst_n=0 with 2 results buffered and b_pend=1 -> all outputs at reset values
//    immediately (async), credits=0.

Source files
------------

// File: rtl/fcmp_axis_issuer.sv
// Issues operand pairs to an AXI-stream float-compare core and buffers its a<b results.
// A credit count caps in-flight requests at DEPTH, so the result FIFO never back-pressures the core.
module fcmp_axis_issuer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic          s_axis_a_tvalid,
  input  logic          s_axis_a_tready,
  output logic [31:0]   s_axis_a_tdata,
  output logic          s_axis_b_tvalid,
  input  logic          s_axis_b_tready,
  output logic [31:0]   s_axis_b_tdata,
  input  logic          m_axis_result_tvalid,
  output logic          m_axis_result_tready,
  input  logic [7:0]    m_axis_result_tdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_lt,
  output logic [CW-1:0] credits,
  output logic          err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  logic             a_pend;
  logic             b_pend;
  logic [31:0]      a_data;
  logic [31:0]      b_data;
  logic [DEPTH-1:0] fifo_mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    credit_cnt;
  logic             err_flag;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] outstanding;
  logic          accept;
  logic          a_fire;
  logic          b_fire;
  logic          res_fire;
  logic          push;
  logic          pop;
  logic          spurious;
  logic          unused_tdata;

  assign unused_tdata = ^m_axis_result_tdata[7:1];

  assign fifo_full   = (count == DepthCnt);
  assign fifo_empty  = (count == '0);
  // Requests issued whose result has not yet landed in the FIFO.
  assign outstanding = credit_cnt - count;

  assign in_ready = !a_pend && !b_pend && (credit_cnt < DepthCnt);
  assign accept   = in_valid && in_ready;
  assign a_fire   = a_pend && s_axis_a_tready;
  assign b_fire   = b_pend && s_axis_b_tready;

  assign m_axis_result_tready = !fifo_full;
  assign res_fire = m_axis_result_tvalid && m_axis_result_tready;
  assign push     = res_fire && (outstanding != '0);
  // A full FIFO implies credits==count, so this also covers results arriving while full.
  assign spurious = m_axis_result_tvalid && (outstanding == '0);

  assign out_valid = !fifo_empty;
  assign out_lt    = fifo_mem[rd_ptr];
  assign pop       = out_valid && out_ready;

  assign s_axis_a_tvalid = a_pend;
  assign s_axis_b_tvalid = b_pend;
  assign s_axis_a_tdata  = a_data;
  assign s_axis_b_tdata  = b_data;
  assign credits         = credit_cnt;
  assign err             = err_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pend     <= 1'b0;
      b_pend     <= 1'b0;
      a_data     <= '0;
      b_data     <= '0;
      fifo_mem   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      credit_cnt <= '0;
      err_flag   <= 1'b0;
    end else begin
      if (accept) begin
        a_data <= in_a;
        b_data <= in_b;
        a_pend <= 1'b1;
        b_pend <= 1'b1;
      end else begin
        if (a_fire) a_pend <= 1'b0;
        if (b_fire) b_pend <= 1'b0;
      end

      if (push) begin
        fifo_mem[wr_ptr] <= m_axis_result_tdata[0];
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case ({accept, pop})
        2'b10:   credit_cnt <= credit_cnt + CW'(1);
        2'b01:   credit_cnt <= credit_cnt - CW'(1);
        default: credit_cnt <= credit_cnt;
      endcase

      if (spurious) err_flag <= 1'b1;
    end
  end

endmodule
